clk_gated_reg_bank: RTL and testbench
=====================================

# clk_gated_reg_bank

Multi-channel register bank in which every channel's flops are clocked through a latch-based integrated clock-gating cell. It is the parametrised successor to the single 8-bit enable register: width and channel count are configurable, and each channel's enable can be explicit, automatic (data-change detect), combined, or forced on. Gating statistics and a bank-idle flag are exported to the power-management logic that sits above the datapath.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of independent channels (1–32)
- CNT_W, 16, width of gated-cycle statistics counter
- IDLE_CYCLES, 8, consecutive all-gated cycles before IDLE asserts (≥1, < 2^CNT_W)

Ports:
- CLK  in  1  free-running clock; the only clock
- RST_N  in  1  asynchronous, active-low reset
- MODE  in  2  gating mode: 00 explicit, 01 auto, 10 explicit AND auto, 11 force-on
- EN  in  CHANNELS  per-channel explicit enable
- D_IN  in  CHANNELS*WIDTH  channel data; channel i = D_IN[i*WIDTH +: WIDTH]
- CNT_CLR  in  1  synchronous clear of GATED_CNT and idle counter
- D_OUT  out  CHANNELS*WIDTH  registered channel data, same packing as D_IN
- GCLK_EN  out  CHANNELS  latched enable of each gating cell (1 = channel clocked this cycle)
- GATED_CNT  out  CNT_W  saturating count of channel-cycles gated off
- IDLE  out  1  bank idle flag

## Operation
- Per-channel request REQ[i]: MODE 00 → EN[i]; 01 → (D_IN_i != D_OUT_i); 10 → EN[i] & (D_IN_i != D_OUT_i); 11 → 1.
- Gating cell per channel: level latch transparent while CLK low, holds while CLK high; gated clock = CLK & latch output. No combinational path from REQ to the gated clock while CLK is high (glitch-free).
- GCLK_EN[i] = latch output of channel i.
- Channel register: at each rising edge of its gated clock, D_OUT_i ← D_IN_i. Functionally equal to D_OUT_i ← REQ[i] ? D_IN_i : D_OUT_i at each CLK rising edge.
- Auto mode never changes the stored value versus explicit-always-on: a gated-off channel already holds D_IN_i.
- GATED_CNT (on ungated CLK): each edge adds popcount(~REQ) and saturates at 2^CNT_W−1. CNT_CLR=1 loads 0, which takes priority over the add.
- Idle counter (on ungated CLK): increments, saturating at IDLE_CYCLES, while all REQ are 0. Any REQ=1 or CNT_CLR=1 loads 0. IDLE is registered and equals (idle counter == IDLE_CYCLES).
- MODE and EN may change in any cycle; the new value takes effect at the next rising edge.

## Timing
- Reset (RST_N=0, asynchronous, dominant over gating): D_OUT=0, GATED_CNT=0, idle counter=0, IDLE=0, latches cleared (GCLK_EN=0).
- Reset release: first rising edge with RST_N=1 evaluates REQ normally. Auto mode with D_IN=0 after reset is gated.
- Data latency: D_IN/EN/MODE stable before rising edge k → D_OUT updated at edge k (1 cycle).
- GCLK_EN reflects REQ sampled during the low phase preceding edge k, and stays stable through the high phase.
- IDLE asserts at the edge that completes IDLE_CYCLES consecutive all-gated edges. It deasserts at the first edge with any REQ=1.
- GATED_CNT update is visible after the same edge whose REQ it counts.
- Reset asserted mid-operation clears all state immediately, regardless of CLK phase or gating state.
- Saturation: GATED_CNT holds at max and does not wrap. Near max, a multi-channel add clamps to max.

## Test plan
- Basic enable, CHANNELS=1, WIDTH=8, MODE=00: D_IN=1, EN=1 → D_OUT=1. D_IN=0, EN=0 → D_OUT stays 1. D_IN=0, EN=1 → 0. 13 with EN=0 after 3 → stays 3. EN=1 → 13. 254 with EN=1 → 254.
- Auto mode, CHANNELS=4: D_IN ch0=5, others held equal to D_OUT → only GCLK_EN[0]=1, D_OUT ch0=5, GATED_CNT +3 per edge.
- Mode 10: EN=4'b1111 with only ch2 data changed → only ch2 clocked. Mode 11 with EN=0 → all channels load and GATED_CNT does not increment.
- Idle: MODE=00, EN=0 for IDLE_CYCLES=8 edges → IDLE=1 at edge 8, not at edge 7. EN[1]=1 for one edge → IDLE=0 at that edge, and recount is required.
- Saturation/clear: CNT_W=4, CHANNELS=4, EN=0 for 4 edges → GATED_CNT=15 and holds. CNT_CLR=1 → 0 next edge, with the clear winning over the add.
- Async reset mid-operation: drive data, pulse RST_N low between edges while CLK is high → D_OUT, GATED_CNT, IDLE and GCLK_EN read 0 immediately. The first edge after release loads normally.

Source files
------------

// File: rtl/clk_gated_reg_bank_if.sv
// Data/control bundle of the clock-gated register bank; CLK and RST_N stay
// plain ports on the bank itself.
interface clk_gated_reg_bank_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16
);
  logic [1:0]                MODE;
  logic [CHANNELS-1:0]       EN;
  logic [CHANNELS*WIDTH-1:0] D_IN;
  logic                      CNT_CLR;
  logic [CHANNELS*WIDTH-1:0] D_OUT;
  logic [CHANNELS-1:0]       GCLK_EN;
  logic [CNT_W-1:0]          GATED_CNT;
  logic                      IDLE;

  modport master (
    output MODE, EN, D_IN, CNT_CLR,
    input  D_OUT, GCLK_EN, GATED_CNT, IDLE
  );

  modport slave (
    input  MODE, EN, D_IN, CNT_CLR,
    output D_OUT, GCLK_EN, GATED_CNT, IDLE
  );
endinterface

// File: rtl/clk_gated_reg_bank.sv
// Multi-channel register bank, each channel clocked through a latch-based
// clock gate; exports gated-cycle statistics and a bank-idle flag.
module clk_gated_reg_bank #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned IDLE_CYCLES = 8
) (
  input logic                  CLK,
  input logic                  RST_N,
  clk_gated_reg_bank_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_EXPLICIT = 2'b00,
    MODE_AUTO     = 2'b01,
    MODE_BOTH     = 2'b10,
    MODE_FORCE    = 2'b11
  } gate_mode_e;

  localparam int unsigned      PC_W     = 6;
  localparam int unsigned      SUM_W    = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);

  gate_mode_e                mode;
  logic [CHANNELS-1:0]       data_chg;
  logic [CHANNELS-1:0]       req;
  logic [CHANNELS-1:0]       gclk_en;
  logic [CHANNELS*WIDTH-1:0] d_q;

  logic [PC_W-1:0]  n_gated;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] gated_cnt_q;
  logic [CNT_W-1:0] gated_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q;
  logic [CNT_W-1:0] idle_cnt_d;
  logic             idle_q;
  logic             all_gated;

  assign mode = gate_mode_e'(bus.MODE);

  always_comb begin
    data_chg = '0;
    req      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      data_chg[i] = (bus.D_IN[i*WIDTH +: WIDTH] != d_q[i*WIDTH +: WIDTH]);
      case (mode)
        MODE_EXPLICIT: req[i] = bus.EN[i];
        MODE_AUTO:     req[i] = data_chg[i];
        MODE_BOTH:     req[i] = bus.EN[i] & data_chg[i];
        MODE_FORCE:    req[i] = 1'b1;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             en_lat;
    logic             gclk;
    logic [WIDTH-1:0] q;

    // Transparent only while CLK is low, so the gated clock cannot glitch.
    always_latch begin
      if (!RST_N)
        en_lat <= 1'b0;
      else if (!CLK)
        en_lat <= req[g];
    end

    assign gclk = CLK & en_lat;

    always_ff @(posedge gclk or negedge RST_N) begin
      if (!RST_N)
        q <= '0;
      else
        q <= bus.D_IN[g*WIDTH +: WIDTH];
    end

    assign d_q[g*WIDTH +: WIDTH] = q;
    assign gclk_en[g]            = en_lat;
  end

  // Statistics use the latched enables, which equal REQ sampled before the edge.
  always_comb begin
    n_gated = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!gclk_en[i])
        n_gated = n_gated + 6'd1;
    end
    all_gated = ~|gclk_en;

    cnt_sum = {{PC_W{1'b0}}, gated_cnt_q} + {{CNT_W{1'b0}}, n_gated};
    if (bus.CNT_CLR)
      gated_cnt_d = '0;
    else if (|cnt_sum[SUM_W-1:CNT_W])
      gated_cnt_d = '1;
    else
      gated_cnt_d = cnt_sum[CNT_W-1:0];

    if (bus.CNT_CLR || !all_gated)
      idle_cnt_d = '0;
    else if (idle_cnt_q == IDLE_LIM)
      idle_cnt_d = idle_cnt_q;
    else
      idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gated_cnt_q <= '0;
      idle_cnt_q  <= '0;
      idle_q      <= 1'b0;
    end else begin
      gated_cnt_q <= gated_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      idle_q      <= (idle_cnt_d == IDLE_LIM);
    end
  end

  assign bus.D_OUT     = d_q;
  assign bus.GCLK_EN   = gclk_en;
  assign bus.GATED_CNT = gated_cnt_q;
  assign bus.IDLE      = idle_q;

endmodule

// File: tb/tb_clk_gated_reg_bank.sv
// Bench for clk_gated_reg_bank: a 1-channel instance driven from a vector
// table and a 4-channel, 4-bit-counter instance checked against a scoreboard.
module tb_clk_gated_reg_bank;

  logic CLK = 1'b0;
  logic RST_N;

  clk_gated_reg_bank_if #(.WIDTH(8), .CHANNELS(1), .CNT_W(16)) bus1 ();
  clk_gated_reg_bank_if #(.WIDTH(8), .CHANNELS(4), .CNT_W(4))  bus4 ();

  clk_gated_reg_bank #(.WIDTH(8), .CHANNELS(1), .CNT_W(16), .IDLE_CYCLES(8)) u1 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus1)
  );
  clk_gated_reg_bank #(.WIDTH(8), .CHANNELS(4), .CNT_W(4), .IDLE_CYCLES(8)) u4 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] dout;
    logic [3:0]  gclk;
    logic [3:0]  cnt;
    logic        idle;
  } exp_t;

  typedef struct {
    logic [7:0]  din;
    logic        en;
    logic [7:0]  dout;
    logic [15:0] cnt;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  logic [31:0] m_dout;
  int unsigned m_cnt;
  int unsigned m_icnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dout = '0;
    m_cnt  = 0;
    m_icnt = 0;
  endtask

  // One clock cycle for the 4-channel bank: predict, push, clock, pop, compare.
  task automatic tick();
    logic [3:0]  req;
    logic [7:0]  a;
    logic [7:0]  b;
    int unsigned ng;
    exp_t        e;
    ng = 0;
    for (int c = 0; c < 4; c++) begin
      a = bus4.D_IN[c*8 +: 8];
      b = m_dout[c*8 +: 8];
      case (bus4.MODE)
        2'b00:   req[c] = bus4.EN[c];
        2'b01:   req[c] = (a != b);
        2'b10:   req[c] = bus4.EN[c] && (a != b);
        default: req[c] = 1'b1;
      endcase
      if (req[c]) m_dout[c*8 +: 8] = a;
      else        ng++;
    end
    if (bus4.CNT_CLR)        m_cnt = 0;
    else if (m_cnt + ng > 15) m_cnt = 15;
    else                     m_cnt = m_cnt + ng;
    if (bus4.CNT_CLR || req != 4'b0) m_icnt = 0;
    else if (m_icnt < 8)             m_icnt++;
    e.dout = m_dout;
    e.gclk = req;
    e.cnt  = 4'(m_cnt);
    e.idle = (m_icnt == 8);
    sb.push_back(e);

    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("u4_dout",      bus4.D_OUT,              e.dout);
    check("u4_gclk_en",   32'(bus4.GCLK_EN),       32'(e.gclk));
    check("u4_gated_cnt", 32'(bus4.GATED_CNT),     32'(e.cnt));
    check("u4_idle",      32'(bus4.IDLE),          32'(e.idle));
    @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_u1_dout"},  32'(bus1.D_OUT),     32'd0);
    check({tag, "_u1_gclk"},  32'(bus1.GCLK_EN),   32'd0);
    check({tag, "_u1_cnt"},   32'(bus1.GATED_CNT), 32'd0);
    check({tag, "_u1_idle"},  32'(bus1.IDLE),      32'd0);
    check({tag, "_u4_dout"},  bus4.D_OUT,          32'd0);
    check({tag, "_u4_gclk"},  32'(bus4.GCLK_EN),   32'd0);
    check({tag, "_u4_cnt"},   32'(bus4.GATED_CNT), 32'd0);
    check({tag, "_u4_idle"},  32'(bus4.IDLE),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] nd;
    vecs[0] = '{8'd1,   1'b1, 8'd1,   16'd0};
    vecs[1] = '{8'd0,   1'b0, 8'd1,   16'd1};
    vecs[2] = '{8'd0,   1'b1, 8'd0,   16'd1};
    vecs[3] = '{8'd3,   1'b1, 8'd3,   16'd1};
    vecs[4] = '{8'd13,  1'b0, 8'd3,   16'd2};
    vecs[5] = '{8'd13,  1'b1, 8'd13,  16'd2};
    vecs[6] = '{8'd254, 1'b1, 8'd254, 16'd2};

    RST_N        = 1'b0;
    bus1.MODE    = 2'b00;
    bus1.EN      = '0;
    bus1.D_IN    = '0;
    bus1.CNT_CLR = 1'b0;
    bus4.MODE    = 2'b01;
    bus4.EN      = '0;
    bus4.D_IN    = '0;
    bus4.CNT_CLR = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RST_N = 1'b1;

    // Single-channel explicit enable; 4-channel bank sits in auto mode with zero data.
    for (int i = 0; i < 7; i++) begin
      bus1.D_IN = vecs[i].din;
      bus1.EN   = vecs[i].en;
      tick();
      check("u1_dout", 32'(bus1.D_OUT),     32'(vecs[i].dout));
      check("u1_gclk", 32'(bus1.GCLK_EN),   32'(vecs[i].en));
      check("u1_cnt",  32'(bus1.GATED_CNT), 32'(vecs[i].cnt));
    end

    bus4.CNT_CLR = 1'b1;
    tick();
    bus4.CNT_CLR = 1'b0;
    check("clr_beats_add", 32'(bus4.GATED_CNT), 32'd0);

    bus4.D_IN = 32'h0000_0005;
    tick();
    check("auto_dout", bus4.D_OUT, 32'h0000_0005);
    check("auto_cnt",  32'(bus4.GATED_CNT), 32'd3);
    bus4.D_IN = 32'h0000_0006;
    tick();
    check("auto_cnt2", 32'(bus4.GATED_CNT), 32'd6);

    bus4.MODE = 2'b10;
    bus4.EN   = 4'hF;
    bus4.D_IN = 32'h0077_0006;
    tick();
    check("both_dout", bus4.D_OUT, 32'h0077_0006);
    check("both_cnt",  32'(bus4.GATED_CNT), 32'd9);

    bus4.MODE = 2'b11;
    bus4.EN   = 4'h0;
    bus4.D_IN = 32'hA1B2_C3D4;
    tick();
    check("force_dout", bus4.D_OUT, 32'hA1B2_C3D4);
    check("force_cnt",  32'(bus4.GATED_CNT), 32'd9);

    bus4.MODE = 2'b00;
    repeat (7) tick();
    check("idle_edge7", 32'(bus4.IDLE), 32'd0);
    tick();
    check("idle_edge8", 32'(bus4.IDLE), 32'd1);
    bus4.EN = 4'b0010;
    tick();
    check("idle_drop", 32'(bus4.IDLE), 32'd0);
    bus4.EN = 4'b0000;
    repeat (7) tick();
    check("idle_recount7", 32'(bus4.IDLE), 32'd0);
    tick();
    check("idle_recount8", 32'(bus4.IDLE), 32'd1);

    bus4.CNT_CLR = 1'b1;
    tick();
    bus4.CNT_CLR = 1'b0;
    check("sat_clr0", 32'(bus4.GATED_CNT), 32'd0);
    repeat (4) tick();
    check("sat_max",  32'(bus4.GATED_CNT), 32'd15);
    tick();
    check("sat_hold", 32'(bus4.GATED_CNT), 32'd15);
    bus4.CNT_CLR = 1'b1;
    tick();
    bus4.CNT_CLR = 1'b0;
    check("sat_clr1", 32'(bus4.GATED_CNT), 32'd0);

    repeat (40) begin
      nd = 32'($urandom);
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 1) == 0) nd[c*8 +: 8] = m_dout[c*8 +: 8];
      bus4.D_IN    = nd;
      bus4.MODE    = 2'($urandom_range(0, 3));
      bus4.EN      = 4'($urandom);
      bus4.CNT_CLR = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus4.CNT_CLR = 1'b0;

    // Asynchronous reset pulsed entirely inside a CLK-high phase.
    bus4.MODE = 2'b11;
    bus4.D_IN = 32'h5A5A_1234;
    bus1.D_IN = 8'h99;
    bus1.EN   = 1'b1;
    tick();
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_all_zero("midreset");
    #1;
    RST_N = 1'b1;
    model_reset();
    @(negedge CLK);
    tick();
    check("post_reset_u1_dout", 32'(bus1.D_OUT),     32'h99);
    check("post_reset_u1_cnt",  32'(bus1.GATED_CNT), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
